// File: rtl/plic_master_pkg.sv
// Shared types and constants for the PLIC claim/complete AXI initiator.
package plic_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_AR        = 3'd1,
    ST_R         = 3'd2,
    ST_DELIVER   = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_WR        = 3'd5,
    ST_B         = 3'd6,
    ST_HOLD      = 3'd7
  } state_e;

  // Claim/complete register of context 0, and the per-context spacing.
  localparam logic [63:0] CLAIM_OFFSET = 64'h0000_0000_0020_0004;
  localparam logic [63:0] CTX_STRIDE   = 64'h0000_0000_0000_1000;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B        = 3'b010;

endpackage

// File: rtl/plic_claim_complete_master.sv
// AXI4 initiator that claims a PLIC interrupt, hands the source ID to a local
// consumer, and writes the same ID back to the complete register when done.
module plic_claim_complete_master
  import plic_master_pkg::*;
#(
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter logic [63:0] PLIC_BASE      = 64'h0000_0000_0C00_0000,
  parameter int unsigned CONTEXT        = 0,
  parameter int unsigned SRC_ID_WIDTH   = 10,
  parameter int unsigned HOLDOFF        = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        irq_i,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [SRC_ID_WIDTH-1:0]     src_id_o,
  output logic                        src_valid_o,
  input  logic                        src_ready_i,
  input  logic                        done_i,
  output logic                        err_o,
  output logic                        busy_o
);

  if (AXI_DATA_WIDTH != 64) begin : g_bad_data_width
    $error("plic_claim_complete_master supports AXI_DATA_WIDTH=64 only");
  end

  localparam logic [63:0] CLAIM_ADDR = PLIC_BASE + CLAIM_OFFSET + 64'(CONTEXT) * CTX_STRIDE;
  localparam logic [7:0]  HOLD_LOAD  = 8'(HOLDOFF);

  state_e      state_q, state_d;
  logic [31:0] claimed_q, claimed_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic [31:0] rd_id;
  logic        rd_oor;
  logic        aw_fire, w_fire;

  assign rd_id   = m_axi_rdata[63:32];
  assign rd_oor  = (SRC_ID_WIDTH < 32) && ((rd_id >> SRC_ID_WIDTH) != '0);
  assign aw_fire = m_axi_awvalid && m_axi_awready;
  assign w_fire  = m_axi_wvalid && m_axi_wready;

  // Next-state logic for the claim / deliver / complete sequence.
  always_comb begin
    state_d    = state_q;
    claimed_d  = claimed_q;
    hold_cnt_d = hold_cnt_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    case (state_q)
      ST_IDLE:      if (irq_i) state_d = ST_AR;
      ST_AR:        if (m_axi_arready) state_d = ST_R;
      ST_R: begin
        if (m_axi_rvalid) begin
          claimed_d = rd_id;
          if (m_axi_rresp != AXI_RESP_OKAY) state_d = ST_IDLE;
          else if (rd_id == '0)             state_d = ST_IDLE;
          else if (rd_oor)                  state_d = ST_WR;
          else                              state_d = ST_DELIVER;
        end
      end
      ST_DELIVER:   if (src_ready_i) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (done_i) state_d = ST_WR;
      ST_WR: begin
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d   = ST_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      ST_B: begin
        if (m_axi_bvalid) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        // Leaving when the count reaches zero gives max(HOLDOFF,1) HOLD cycles.
        hold_cnt_d = (hold_cnt_q != '0) ? hold_cnt_q - 8'd1 : '0;
        if (hold_cnt_q <= 8'd1) state_d = ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  // State, claimed ID, holdoff counter and write-channel completion flags.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      claimed_q  <= '0;
      hold_cnt_q <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      claimed_q  <= claimed_d;
      hold_cnt_q <= hold_cnt_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = CLAIM_ADDR[AXI_ADDR_WIDTH-1:0];
  assign m_axi_arlen   = '0;
  assign m_axi_arsize  = SIZE_4B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arvalid = (state_q == ST_AR);
  assign m_axi_rready  = (state_q == ST_R);

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = CLAIM_ADDR[AXI_ADDR_WIDTH-1:0];
  assign m_axi_awlen   = '0;
  assign m_axi_awsize  = SIZE_4B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awvalid = (state_q == ST_WR) && !aw_done_q;
  assign m_axi_wdata   = {claimed_q, 32'h0};
  assign m_axi_wstrb   = 8'hF0;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_wvalid  = (state_q == ST_WR) && !w_done_q;
  assign m_axi_bready  = (state_q == ST_B);

  assign src_id_o    = claimed_q[SRC_ID_WIDTH-1:0];
  assign src_valid_o = (state_q == ST_DELIVER);
  assign busy_o      = (state_q != ST_IDLE);

  assign err_o = ((state_q == ST_R) && m_axi_rvalid &&
                  ((m_axi_rresp != AXI_RESP_OKAY) || rd_oor)) ||
                 ((state_q == ST_B) && m_axi_bvalid && (m_axi_bresp != AXI_RESP_OKAY));

  logic unused_inputs;
  assign unused_inputs = ^{m_axi_rid, m_axi_rlast, m_axi_bid, m_axi_rdata[31:0]};

endmodule
